// File: rtl/cache_miss_stall_controller_pkg.sv
// Shared types and helpers for the data-cache miss controller (package miss_ctrl_pkg).
package miss_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2,
        DONE      = 2'd3
    } miss_state_t;

    localparam int WORD_BYTES = 4;

    // Number of low address bits covered by one cache line.
    function automatic int line_offset_width(input int block_words);
        return $clog2(block_words) + $clog2(WORD_BYTES);
    endfunction

endpackage

// File: rtl/cache_miss_stall_controller_burst_word_counter.sv
// Word index counter shared by the write-back and refill bursts.
module burst_word_counter #(
    parameter int BLOCK_WORDS = 4,
    parameter int WORD_IDX_W  = $clog2(BLOCK_WORDS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  increment,
    output logic [WORD_IDX_W-1:0] word_idx,
    output logic                  last_word
);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            word_idx <= '0;
        end else if (increment) begin
            word_idx <= word_idx + 1'b1;
        end
    end

    assign last_word = (word_idx == WORD_IDX_W'(BLOCK_WORDS - 1));

endmodule

// File: rtl/cache_miss_stall_controller.sv
// Data-cache miss sequencer: stalls the pipeline, writes back a dirty victim, refills the line.
// Optional performance counters are enabled by defining STALL_CTRL_PERF_EN.
module cache_miss_stall_controller
    import miss_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int BLOCK_WORDS = 4,
    parameter int WORD_IDX_W  = $clog2(BLOCK_WORDS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [ADDR_WIDTH-1:0] access_address,
    input  logic                  cache_hit,
    input  logic                  victim_dirty,
    input  logic [ADDR_WIDTH-1:0] victim_tag_address,
    input  logic                  mem_ready,
    output logic                  hit,
    output logic                  mem_request,
    output logic                  mem_write_enable,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  cache_fill_enable,
    output logic [WORD_IDX_W-1:0] fill_word_index,
    output logic [31:0]           miss_count,
    output logic [31:0]           stall_cycles
);

    localparam int OFFSET_W = line_offset_width(BLOCK_WORDS);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
        ~((ADDR_WIDTH'(1) << OFFSET_W) - ADDR_WIDTH'(1));

    miss_state_t           state;
    logic [ADDR_WIDTH-1:0] line_base;
    logic [ADDR_WIDTH-1:0] victim_base;
    logic [ADDR_WIDTH-1:0] word_offset;
    logic [WORD_IDX_W-1:0] word_idx;
    logic                  last_word;
    logic                  access;
    logic                  miss;
    logic                  transfer;
    logic                  burst_done;
    logic                  counter_clear;

    assign access        = mem_read | mem_write;
    assign miss          = access & ~cache_hit;
    assign transfer      = ((state == WRITEBACK) || (state == REFILL)) && mem_ready;
    assign burst_done    = transfer && last_word;
    assign counter_clear = (state == IDLE) || burst_done;

    burst_word_counter #(
        .BLOCK_WORDS (BLOCK_WORDS),
        .WORD_IDX_W  (WORD_IDX_W)
    ) u_word_counter (
        .clock     (clock),
        .reset     (reset),
        .clear     (counter_clear),
        .increment (transfer),
        .word_idx  (word_idx),
        .last_word (last_word)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            line_base   <= '0;
            victim_base <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss) begin
                        line_base   <= access_address & LINE_MASK;
                        victim_base <= victim_tag_address;
                        state       <= victim_dirty ? WRITEBACK : REFILL;
                    end
                end
                WRITEBACK: if (burst_done) state <= REFILL;
                REFILL:    if (burst_done) state <= DONE;
                DONE:      state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

    // Stall is combinational so the pipeline freezes on the edge that detects the miss.
    assign word_offset       = ADDR_WIDTH'(word_idx) * ADDR_WIDTH'(WORD_BYTES);
    assign hit               = (state == IDLE) && !miss;
    assign mem_request       = (state == WRITEBACK) || (state == REFILL);
    assign mem_write_enable  = (state == WRITEBACK);
    assign cache_fill_enable = (state == REFILL) && mem_ready;
    assign fill_word_index   = word_idx;

    always_comb begin
        mem_address = '0;
        case (state)
            WRITEBACK: mem_address = victim_base + word_offset;
            REFILL:    mem_address = line_base + word_offset;
            default:   mem_address = '0;
        endcase
    end

`ifdef STALL_CTRL_PERF_EN
    // Stall cycles are the miss penalty, i.e. every cycle spent outside IDLE.
    always_ff @(posedge clock) begin
        if (reset) begin
            miss_count   <= '0;
            stall_cycles <= '0;
        end else begin
            if ((state == IDLE) && miss && (miss_count != '1)) begin
                miss_count <= miss_count + 32'd1;
            end
            if ((state != IDLE) && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end
`else
    assign miss_count   = '0;
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_cache_miss_stall_controller.sv
// Self-checking bench for cache_miss_stall_controller: vector table, directed miss sequences,
// and random traffic checked against a transfer-queue reference model.
module tb_cache_miss_stall_controller;

    localparam int AW = 32;
    localparam int BW = 4;
    localparam int IW = 2;
    localparam logic [31:0] LINE_BYTES = 32'd16;

    logic          clock = 1'b0;
    logic          reset;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] access_address;
    logic          cache_hit;
    logic          victim_dirty;
    logic [AW-1:0] victim_tag_address;
    logic          mem_ready;
    logic          hit;
    logic          mem_request;
    logic          mem_write_enable;
    logic [AW-1:0] mem_address;
    logic          cache_fill_enable;
    logic [IW-1:0] fill_word_index;
    logic [31:0]   miss_count;
    logic [31:0]   stall_cycles;

    cache_miss_stall_controller #(
        .ADDR_WIDTH  (AW),
        .BLOCK_WORDS (BW)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .mem_read           (mem_read),
        .mem_write          (mem_write),
        .access_address     (access_address),
        .cache_hit          (cache_hit),
        .victim_dirty       (victim_dirty),
        .victim_tag_address (victim_tag_address),
        .mem_ready          (mem_ready),
        .hit                (hit),
        .mem_request        (mem_request),
        .mem_write_enable   (mem_write_enable),
        .mem_address        (mem_address),
        .cache_fill_enable  (cache_fill_enable),
        .fill_word_index    (fill_word_index),
        .miss_count         (miss_count),
        .stall_cycles       (stall_cycles)
    );

    always #5 clock = ~clock;

    // Reference model: a miss expands into an ordered list of word transfers,
    // followed by one extra stall cycle before the pipeline is released.
    typedef struct {
        logic        we;
        logic [31:0] addr;
        int          idx;
    } xfer_t;

    xfer_t q[$];
    bit    done_pending;
    int    model_misses;
    int    model_stalls;
    int    checks;
    int    failures;
    logic  obs_hit;

    typedef struct {
        logic        mr;
        logic        ch;
        logic [31:0] addr;
        logic        rdy;
        logic        e_hit;
        logic        e_req;
        logic        e_we;
        logic [31:0] e_addr;
        logic        e_fill;
        logic [1:0]  e_idx;
    } vec_t;

    vec_t tbl[7];

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic model_step(input logic mr, input logic mw, input logic [31:0] addr,
                              input logic ch, input logic vd, input logic [31:0] vt,
                              input logic rdy);
        bit    in_seq;
        bit    m;
        xfer_t head;
        in_seq = (q.size() > 0) || done_pending;
        m      = (mr || mw) && !ch;
        check_output("hit", 32'(hit), 32'(!in_seq && !m));
        check_output("mem_request", 32'(mem_request), 32'(q.size() > 0));
        if (q.size() > 0) begin
            head = q[0];
            check_output("mem_write_enable", 32'(mem_write_enable), 32'(head.we));
            check_output("mem_address", mem_address, head.addr);
            check_output("cache_fill_enable", 32'(cache_fill_enable), 32'(rdy && !head.we));
            if (rdy && !head.we) check_output("fill_word_index", 32'(fill_word_index), 32'(head.idx));
        end else begin
            check_output("cache_fill_enable_idle", 32'(cache_fill_enable), 32'd0);
        end
`ifdef STALL_CTRL_PERF_EN
        check_output("miss_count", miss_count, 32'(model_misses));
        check_output("stall_cycles", stall_cycles, 32'(model_stalls));
`else
        check_output("miss_count_tied", miss_count, 32'd0);
        check_output("stall_cycles_tied", stall_cycles, 32'd0);
`endif
        if (in_seq) model_stalls++;
        if (q.size() > 0) begin
            if (rdy) begin
                void'(q.pop_front());
                if (q.size() == 0) done_pending = 1'b1;
            end
        end else if (done_pending) begin
            done_pending = 1'b0;
        end else if (m) begin
            model_misses++;
            if (vd) for (int i = 0; i < BW; i++) q.push_back('{1'b1, vt + 32'(4 * i), i});
            for (int i = 0; i < BW; i++)
                q.push_back('{1'b0, (addr & ~(LINE_BYTES - 32'd1)) + 32'(4 * i), i});
        end
    endtask

    task automatic apply_stimulus(input logic rst, input logic mr, input logic mw,
                                  input logic [31:0] addr, input logic ch, input logic vd,
                                  input logic [31:0] vt, input logic rdy);
        @(posedge clock);
        #1;
        reset              = rst;
        mem_read           = mr;
        mem_write          = mw;
        access_address     = addr;
        cache_hit          = ch;
        victim_dirty       = vd;
        victim_tag_address = vt;
        mem_ready          = rdy;
        @(negedge clock);
        obs_hit = hit;
        if (rst) begin
            q.delete();
            done_pending = 1'b0;
            model_misses = 0;
            model_stalls = 0;
        end else begin
            model_step(mr, mw, addr, ch, vd, vt, rdy);
        end
    endtask

    // Miss followed by a stall whose length (after the detection cycle) must match penalty.
    task automatic run_miss(input logic [31:0] addr, input logic vd, input logic [31:0] vt,
                            input int period, input int penalty, input string name);
        int stall;
        stall = 0;
        apply_stimulus(1'b0, 1'b1, 1'b0, addr, 1'b0, vd, vt, 1'b0);
        for (int k = 0; k < 200; k++) begin
            apply_stimulus(1'b0, 1'b1, 1'b0, addr, 1'b1, 1'b0, vt, ((k % period) == period - 1));
            if (obs_hit) break;
            stall++;
        end
        check_output(name, 32'(stall), 32'(penalty));
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        done_pending = 1'b0;
        model_misses = 0;
        model_stalls = 0;

        tbl[0] = '{1'b1, 1'b0, 32'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 2'd0};
        tbl[1] = '{1'b1, 1'b1, 32'h1234, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1230, 1'b1, 2'd0};
        tbl[2] = '{1'b1, 1'b1, 32'h1234, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1234, 1'b1, 2'd1};
        tbl[3] = '{1'b1, 1'b1, 32'h1234, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1238, 1'b1, 2'd2};
        tbl[4] = '{1'b1, 1'b1, 32'h1234, 1'b1, 1'b0, 1'b1, 1'b0, 32'h123C, 1'b1, 2'd3};
        tbl[5] = '{1'b1, 1'b1, 32'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 2'd0};
        tbl[6] = '{1'b1, 1'b1, 32'h1234, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,    1'b0, 2'd0};

        apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        check_output("reset_hit", 32'(hit), 32'd1);
        check_output("reset_mem_address", mem_address, 32'h0);
        check_output("reset_fill_word_index", 32'(fill_word_index), 32'd0);
        check_output("reset_mem_write_enable", 32'(mem_write_enable), 32'd0);

        $display("[TB] hit path");
        for (int i = 0; i < 5; i++)
            apply_stimulus(1'b0, 1'b1, 1'b0, 32'h100, 1'b1, 1'b1, 32'h8000, 1'($urandom % 2));

        $display("[TB] clean miss vector table");
        for (int i = 0; i < 7; i++) begin
            apply_stimulus(1'b0, tbl[i].mr, 1'b0, tbl[i].addr, tbl[i].ch, 1'b0, 32'h0, tbl[i].rdy);
            check_output($sformatf("tbl%0d_hit", i), 32'(hit), 32'(tbl[i].e_hit));
            check_output($sformatf("tbl%0d_req", i), 32'(mem_request), 32'(tbl[i].e_req));
            check_output($sformatf("tbl%0d_fill", i), 32'(cache_fill_enable), 32'(tbl[i].e_fill));
            if (tbl[i].e_req) begin
                check_output($sformatf("tbl%0d_we", i), 32'(mem_write_enable), 32'(tbl[i].e_we));
                check_output($sformatf("tbl%0d_addr", i), mem_address, tbl[i].e_addr);
            end
            if (tbl[i].e_fill)
                check_output($sformatf("tbl%0d_idx", i), 32'(fill_word_index), 32'(tbl[i].e_idx));
        end

        $display("[TB] directed miss sequences");
        run_miss(32'h1234, 1'b0, 32'h8000, 1, 5, "clean_penalty");
        run_miss(32'h0040, 1'b1, 32'h8000, 1, 9, "dirty_penalty");
        run_miss(32'h1234, 1'b0, 32'h8000, 3, 13, "slow_penalty");

        $display("[TB] reset mid-refill");
        apply_stimulus(1'b0, 1'b1, 1'b0, 32'h2000, 1'b0, 1'b0, 32'h0, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 32'h2000, 1'b1, 1'b0, 32'h0, 1'b1);
        apply_stimulus(1'b0, 1'b1, 1'b0, 32'h2000, 1'b1, 1'b0, 32'h0, 1'b1);
        apply_stimulus(1'b1, 1'b1, 1'b0, 32'h2000, 1'b1, 1'b0, 32'h0, 1'b1);
        apply_stimulus(1'b0, 1'b1, 1'b0, 32'h2000, 1'b1, 1'b0, 32'h0, 1'b1);
        check_output("rst_mid_hit", 32'(hit), 32'd1);
        check_output("rst_mid_req", 32'(mem_request), 32'd0);
        check_output("rst_mid_miss_count", miss_count, 32'd0);
        check_output("rst_mid_stall_cycles", stall_cycles, 32'd0);

        run_miss(32'h3000, 1'b0, 32'h0, 1, 5, "perf_miss1");
        run_miss(32'h3010, 1'b0, 32'h0, 1, 5, "perf_miss2");
`ifdef STALL_CTRL_PERF_EN
        check_output("perf_miss_count", miss_count, 32'd2);
        check_output("perf_stall_cycles", stall_cycles, 32'd10);
`else
        check_output("perf_miss_count", miss_count, 32'd0);
        check_output("perf_stall_cycles", stall_cycles, 32'd0);
`endif

        $display("[TB] random traffic");
        for (int i = 0; i < 1500; i++) begin
            apply_stimulus(1'(($urandom % 150) == 0), 1'($urandom % 2), 1'(($urandom % 4) == 0),
                           $urandom, 1'(($urandom % 3) != 0), 1'($urandom % 2),
                           $urandom & 32'hFFFF_FFF0, 1'(($urandom % 3) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
